// File: rtl/cordic_vect.sv
// Circular-vectoring CORDIC: converts a Cartesian vector (x, y) into its
// gain-compensated magnitude and its angle atan2(y, x).
// One micro-rotation per clock, start/done handshake.
// Angle scaling: 90 deg = 65536. The arctangent table matches the rotation CORDIC.
`timescale 1ns/1ps

module cordic_vect #(
    parameter int IO_WIDTH    = 18,
    parameter int ITER_NUM    = 15,
    parameter int GUARD       = 2,
    parameter int SCALE_CONS  = 622,
    parameter int SCALE_SHIFT = 10
) (
    input  logic                       sys_clk_i,
    input  logic                       reset_i,
    input  logic                       start_i,
    input  logic signed [IO_WIDTH-1:0] x_i,
    input  logic signed [IO_WIDTH-1:0] y_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic signed [IO_WIDTH-1:0] mag_o,
    output logic signed [IO_WIDTH-1:0] theta_o
);

    localparam int DW = IO_WIDTH + GUARD;
    localparam int ZW = IO_WIDTH + 1;
    localparam int PW = DW + 16;
    localparam int IW = 5;

    localparam logic signed [DW-1:0] MAG_MAX = DW'((2 ** (IO_WIDTH - 1)) - 1);
    localparam logic signed [ZW-1:0] TH_MAX  = ZW'((2 ** (IO_WIDTH - 1)) - 1);
    localparam logic signed [ZW-1:0] TH_MIN  = -TH_MAX;
    localparam logic signed [ZW-1:0] QUARTER = ZW'(65536);
    localparam logic signed [PW-1:0] SCALE_K = PW'(SCALE_CONS);

    typedef enum logic [1:0] {
        IDLE,
        ROT,
        SCALE,
        OUT
    } state_t;

    state_t                state_q, state_d;
    logic signed [DW-1:0]  x_q, x_d;
    logic signed [DW-1:0]  y_q, y_d;
    logic signed [ZW-1:0]  z_q, z_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  zero_q, zero_d;
    logic signed [DW-1:0]  m_q, m_d;
    logic signed [IO_WIDTH-1:0] mag_q, mag_d;
    logic signed [IO_WIDTH-1:0] theta_q, theta_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic signed [DW-1:0]  xExt;
    logic signed [DW-1:0]  yExt;
    logic signed [PW-1:0]  prod;
    logic signed [ZW-1:0]  atanVal;

    // Arctangent of 2^-i in the 90 deg = 65536 scaling.
    function automatic logic signed [ZW-1:0] atanLut(input logic [IW-1:0] i);
        case (i)
            5'd0:    atanLut = ZW'(32768);
            5'd1:    atanLut = ZW'(19344);
            5'd2:    atanLut = ZW'(10221);
            5'd3:    atanLut = ZW'(5188);
            5'd4:    atanLut = ZW'(2604);
            5'd5:    atanLut = ZW'(1303);
            5'd6:    atanLut = ZW'(652);
            5'd7:    atanLut = ZW'(326);
            5'd8:    atanLut = ZW'(163);
            5'd9:    atanLut = ZW'(81);
            5'd10:   atanLut = ZW'(41);
            5'd11:   atanLut = ZW'(20);
            5'd12:   atanLut = ZW'(10);
            5'd13:   atanLut = ZW'(5);
            5'd14:   atanLut = ZW'(3);
            5'd15:   atanLut = ZW'(1);
            default: atanLut = ZW'(0);
        endcase
    endfunction

    // Next-state and datapath logic. ROT spends one extra cycle to observe the
    // terminal iteration count before handing off to SCALE.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        idx_d   = idx_q;
        zero_d  = zero_q;
        m_d     = m_q;
        mag_d   = mag_q;
        theta_d = theta_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        xExt    = {{GUARD{x_i[IO_WIDTH-1]}}, x_i};
        yExt    = {{GUARD{y_i[IO_WIDTH-1]}}, y_i};
        prod    = PW'(x_q) * SCALE_K;
        atanVal = atanLut(idx_q);

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    // Pre-rotate vectors in the left half-plane by +/-90 deg.
                    if (!x_i[IO_WIDTH-1]) begin
                        x_d = xExt;
                        y_d = yExt;
                        z_d = '0;
                    end else if (!y_i[IO_WIDTH-1]) begin
                        x_d = yExt;
                        y_d = -xExt;
                        z_d = QUARTER;
                    end else begin
                        x_d = -yExt;
                        y_d = xExt;
                        z_d = -QUARTER;
                    end
                    zero_d  = (x_i == '0) && (y_i == '0);
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ROT;
                end
            end
            ROT: begin
                if (idx_q == IW'(ITER_NUM)) begin
                    state_d = SCALE;
                end else begin
                    if (!y_q[DW-1]) begin
                        x_d = x_q + (y_q >>> idx_q);
                        y_d = y_q - (x_q >>> idx_q);
                        z_d = z_q + atanVal;
                    end else begin
                        x_d = x_q - (y_q >>> idx_q);
                        y_d = y_q + (x_q >>> idx_q);
                        z_d = z_q - atanVal;
                    end
                    idx_d = idx_q + 1'b1;
                end
            end
            SCALE: begin
                m_d     = DW'(prod >>> SCALE_SHIFT);
                state_d = OUT;
            end
            OUT: begin
                if (zero_q) begin
                    mag_d   = '0;
                    theta_d = '0;
                end else begin
                    if (m_q > MAG_MAX) begin
                        mag_d = IO_WIDTH'(MAG_MAX);
                    end else if (m_q[DW-1]) begin
                        mag_d = '0;
                    end else begin
                        mag_d = IO_WIDTH'(m_q);
                    end
                    if (z_q > TH_MAX) begin
                        theta_d = IO_WIDTH'(TH_MAX);
                    end else if (z_q < TH_MIN) begin
                        theta_d = IO_WIDTH'(TH_MIN);
                    end else begin
                        theta_d = IO_WIDTH'(z_q);
                    end
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge sys_clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            idx_q   <= '0;
            zero_q  <= 1'b0;
            m_q     <= '0;
            mag_q   <= '0;
            theta_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            idx_q   <= idx_d;
            zero_q  <= zero_d;
            m_q     <= m_d;
            mag_q   <= mag_d;
            theta_q <= theta_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign mag_o   = mag_q;
    assign theta_o = theta_q;

endmodule

// File: tb/tb_cordic_vect.sv
// Scoreboard bench for cordic_vect: stimulus pushes expected results with a
// tolerance and the done cycle; a monitor pops and compares on every done pulse.
`timescale 1ns/1ps

module tb_cordic_vect;

    localparam int W = 18;

    logic                sysClk = 1'b0;
    logic                resetN = 1'b0;
    logic                start  = 1'b0;
    logic signed [W-1:0] xIn    = '0;
    logic signed [W-1:0] yIn    = '0;
    logic                busy;
    logic                done;
    logic signed [W-1:0] mag;
    logic signed [W-1:0] theta;

    typedef struct {
        string tag;
        int    expMag;
        int    magTol;
        int    expTheta;
        int    thetaTol;
        int    doneCycle;
    } expT;

    expT  sbQ[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cycle      = 0;
    logic prevDone   = 1'b0;

    cordic_vect dut (
        .sys_clk_i (sysClk),
        .reset_i   (resetN),
        .start_i   (start),
        .x_i       (xIn),
        .y_i       (yIn),
        .busy_o    (busy),
        .done_o    (done),
        .mag_o     (mag),
        .theta_o   (theta)
    );

    // 100 MHz clock.
    always #5 sysClk = ~sysClk;

    // Free-running cycle counter used to time the done pulse.
    always @(posedge sysClk) cycle <= cycle + 1;

    // Compare one value against an expectation with a tolerance.
    task automatic checkOutput(input string tag, input int actual, input int expected, input int tol);
        compared++;
        if ((actual - expected > tol) || (expected - actual > tol)) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d +/- %0d", tag, actual, expected, tol);
        end
    endtask

    // Pop the oldest expectation and check a completed operation against it.
    task automatic checkDone();
        expT e;
        checkOutput("done-width", int'(prevDone), 0, 0);
        if (sbQ.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected-done: got done at cycle %0d, expected none", cycle);
        end else begin
            e = sbQ.pop_front();
            checkOutput({e.tag, "-latency"}, cycle, e.doneCycle, 0);
            checkOutput({e.tag, "-mag"}, int'(mag), e.expMag, e.magTol);
            checkOutput({e.tag, "-theta"}, int'(theta), e.expTheta, e.thetaTol);
        end
    endtask

    // Monitor: sample away from the active edge and check on every done pulse.
    always @(negedge sysClk) begin
        if (resetN && done) checkDone();
        prevDone <= done;
    end

    // Issue one operation, record its expectation, scramble inputs while busy.
    task automatic applyStimulus(input logic signed [W-1:0] x, input logic signed [W-1:0] y,
                                 input string tag, input int eMag, input int mTol,
                                 input int eTh, input int tTol);
        xIn   = x;
        yIn   = y;
        start = 1'b1;
        @(posedge sysClk);
        #1;
        sbQ.push_back('{tag, eMag, mTol, eTh, tTol, cycle + 18});
        start = 1'b0;
        xIn   = W'($urandom);
        yIn   = W'($urandom);
        checkOutput({tag, "-busy"}, int'(busy), 1, 0);
        repeat (19) @(posedge sysClk);
        #1;
    endtask

    initial begin
        // Reset held with start asserted: nothing may start.
        resetN = 1'b0;
        start  = 1'b1;
        xIn    = 18'sd5000;
        yIn    = 18'sd5000;
        repeat (3) @(posedge sysClk);
        #1;
        checkOutput("reset-busy", int'(busy), 0, 0);
        checkOutput("reset-done", int'(done), 0, 0);
        checkOutput("reset-mag", int'(mag), 0, 0);
        checkOutput("reset-theta", int'(theta), 0, 0);
        start  = 1'b0;
        resetN = 1'b1;
        @(posedge sysClk);
        #1;

        // Axes, diagonal, quadrants II/III, clamp and extremes.
        applyStimulus(18'sd10000, 18'sd0, "x-axis", 10003, 14, 0, 8);
        applyStimulus(18'sd0, 18'sd10000, "y-axis", 10003, 14, 65536, 8);
        applyStimulus(18'sd7071, 18'sd7071, "diag45", 10003, 14, 32768, 8);
        applyStimulus(-18'sd10000, 18'sd10000, "quad2", 14146, 18, 98304, 8);
        applyStimulus(-18'sd10000, -18'sd10000, "quad3", 14146, 18, -98304, 8);
        applyStimulus(-18'sd10000, 18'sd0, "neg-x-clamp", 10003, 14, 131071, 8);
        applyStimulus(-18'sd131072, -18'sd131072, "extreme-sat", 131071, 0, -98304, 8);
        applyStimulus(18'sd0, 18'sd0, "zero-vec", 0, 0, 0, 0);

        // start held high for 40 cycles: accepts at edges 0, 19 and 38 only;
        // inputs are garbage except just before each accepting edge.
        xIn   = 18'sd10000;
        yIn   = 18'sd0;
        start = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(posedge sysClk);
            #1;
            if (n == 0)  sbQ.push_back('{"held-a", 10003, 14, 0, 8, cycle + 18});
            if (n == 19) sbQ.push_back('{"held-b", 10003, 14, -65536, 8, cycle + 18});
            if (n == 38) sbQ.push_back('{"held-c", 5001, 10, 38689, 8, cycle + 18});
            if (n + 1 == 19) begin
                xIn = 18'sd0;
                yIn = -18'sd10000;
            end else if (n + 1 == 38) begin
                xIn = 18'sd3000;
                yIn = 18'sd4000;
            end else begin
                xIn = W'($urandom);
                yIn = W'($urandom);
            end
        end
        start = 1'b0;
        repeat (20) @(posedge sysClk);
        #1;

        // Reset around iteration 7 aborts the operation and clears the outputs.
        xIn   = 18'sd20000;
        yIn   = 18'sd1000;
        start = 1'b1;
        @(posedge sysClk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge sysClk);
        #1;
        resetN = 1'b0;
        #1;
        checkOutput("abort-busy", int'(busy), 0, 0);
        checkOutput("abort-mag", int'(mag), 0, 0);
        @(posedge sysClk);
        #1;
        resetN = 1'b1;
        repeat (25) @(posedge sysClk);
        #1;
        applyStimulus(18'sd3000, -18'sd4000, "after-abort", 5001, 10, -38689, 8);

        repeat (3) @(posedge sysClk);
        #1;
        checkOutput("scoreboard-empty", sbQ.size(), 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cordic_vect.md
Name: cordic_vect

Overview:
- Circular-vectoring-mode CORDIC. It is the inverse of the rotation-mode CORDIC used in the FOC datapath.
- Takes a Cartesian vector (x, y), e.g. stator current in the alpha/beta frame, and returns its gain-compensated magnitude and its angle atan2(y, x).
- Sits next to the rotation CORDIC. Uses the same angle scaling and the same arctangent table.
- Iterative design: one micro-rotation per clock, start/done handshake.

Parameters:
- IO_WIDTH, 18, width of all data ports. The angle table is defined for 18.
- ITER_NUM, 15, number of micro-rotations; legal range 1..16.
- GUARD, 2, extra MSBs on the internal x/y datapath to absorb CORDIC gain (1.647) and the sqrt(2) growth.
- SCALE_CONS, 622, 1/K compensation multiplier: 622/1024 = 0.6074.
- SCALE_SHIFT, 10, right shift applied after the SCALE_CONS multiply.

Ports:
- sys_clk_i  in  1  system clock; all state updates on the rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- start_i  in  1  single-cycle request; sampled only in IDLE.
- x_i  in  IO_WIDTH  signed x coordinate.
- y_i  in  IO_WIDTH  signed y coordinate.
- busy_o  out  1  high from the start-accept edge until the done edge.
- done_o  out  1  single-cycle pulse; mag_o and theta_o are valid from this cycle on.
- mag_o  out  IO_WIDTH  signed, always >= 0; gain-compensated magnitude.
- theta_o  out  IO_WIDTH  signed angle. 90 deg = 65536; +/-180 deg clamps to +/-131071.

Behaviour:
- Reset (reset_i = 0, asynchronous):
  - state = IDLE; all datapath registers cleared.
  - busy_o = 0, done_o = 0, mag_o = 0, theta_o = 0.
  - Reset asserted mid-operation aborts the operation; no done_o is produced.
- States: IDLE -> ROT -> SCALE -> OUT -> IDLE.
- IDLE:
  - When start_i = 1 on an edge: capture the inputs with pre-rotation applied, set iteration index to 0, go to ROT, busy_o = 1.
  - Pre-rotation, sign-extended to IO_WIDTH+GUARD bits:
    - x >= 0: x' = x, y' = y, z = 0.
    - x < 0 and y >= 0: x' = y, y' = -x, z = +65536.
    - x < 0 and y < 0: x' = -y, y' = x, z = -65536.
  - Angle accumulator z is IO_WIDTH+1 bits.
  - Capture a zero flag = (x_i == 0 && y_i == 0).
- ROT, one iteration per cycle for i = 0..ITER_NUM-1:
  - If y >= 0: x += y>>>i, y -= x>>>i, z += ATAN[i].
  - If y < 0: x -= y>>>i, y += x>>>i, z -= ATAN[i].
  - Both updates use the old x and y (simultaneous update). Shifts are arithmetic.
  - After iteration ITER_NUM-1, go to SCALE.
- ATAN table (index 0..15): 32768, 19344, 10221, 5188, 2604, 1303, 652, 326, 163, 81, 41, 20, 10, 5, 3, 1.
- SCALE (1 cycle):
  - Product p = x * SCALE_CONS, computed in full width.
  - m = p >>> SCALE_SHIFT, registered.
- OUT (1 cycle):
  - mag_o = min(m, 2^(IO_WIDTH-1)-1).
  - theta_o = z clamped to [-131071, +131071].
  - If the zero flag is set, mag_o = 0 and theta_o = 0.
  - done_o = 1 for exactly this one cycle; busy_o = 0 from the same edge; go to IDLE.
- Latency: start_i sampled at edge k -> done_o high after edge k+ITER_NUM+3, i.e. 18 cycles at default.
- Outputs hold their last value until the next done_o.
- start_i while busy_o = 1 (including the OUT-state edge) is ignored. The earliest accepted restart is the cycle in which done_o is high, sampled at the following edge (state is then IDLE).
- Inputs need only be stable on the accepting edge.
- Accuracy at defaults: |theta_o error| <= 8 LSB; magnitude error <= 0.1% + 4 LSB.

Test Plan:
- Reset 0 for 3 cycles with start_i = 1 -> all outputs 0, busy_o = 0. Release, pulse start with x = 10000, y = 0 -> done_o exactly 18 cycles after the accepting edge; mag_o = 10000 +/- 14, theta_o = 0 +/- 8.
- x = 0, y = 10000 -> theta_o = 65536 +/- 8, mag_o = 10000 +/- 14. Then x = 7071, y = 7071 -> theta_o = 32768 +/- 8, mag_o = 10000 +/- 14.
- Quadrants II/III:
  - x = -10000, y = 10000 -> theta_o = 98304 +/- 8.
  - x = -10000, y = -10000 -> theta_o = -98304 +/- 8; mag_o = 14142 +/- 18.
  - x = -10000, y = 0 -> theta_o = 131071 (clamped).
- Extremes:
  - x = y = -131072 -> mag_o = 131071 (saturated), theta_o = -98304 +/- 8.
  - x = y = 0 -> mag_o = 0, theta_o = 0.
- Handshake:
  - start_i held high for 40 cycles -> one operation per 19 cycles; done_o is never 2 cycles wide; changes to x_i/y_i while busy_o is high do not affect results.
  - reset_i low at iteration 7 -> no done_o; after release, a new start gives the correct result.
- Random sweep of 10^4 vectors against an atan2/hypot reference model -> all results within the stated accuracy.
